factorial_bcd_out: RTL and testbench
====================================

// Module: factorial_bcd_out
// PURPOSE
//  Downstream result stage for the factorial unit. Captures the 8-bit result
//  (Out) on each rising edge of done and converts it to packed BCD with a
//  sequential shift-add-3 (double-dabble) engine, one bit per clock.
//  Presents the digits on a valid/ready handshake for the display or
//  host-readout logic.
// PARAMETERS
//  WIDTH   8   binary input width; also the number of SHIFT cycles
//  DIGITS  3   BCD digits out; must satisfy 10**DIGITS > 2**WIDTH-1
// PORTS
//  clk      in   1           single clock, rising edge
//  rst_n    in   1           asynchronous, active-low reset
//  done_i   in   1           factorial done level; a rising edge means a new result
//  data_i   in   WIDTH       factorial result (Out); sampled on the done_i rising edge
//  bcd_o    out  4*DIGITS    packed BCD; digit 0 in bits [3:0]
//  valid_o  out  1           bcd_o holds a new, unconsumed result
//  ready_i  in   1           consumer accepts when valid_o && ready_i
//  busy_o   out  1           high in SHIFT and HOLD
//  drop_o   out  1           1-cycle pulse: a done edge was ignored because the block was busy
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; valid_o=0, busy_o=0, drop_o=0, bcd_o=0.
//   - done_q=1, so a done_i level already high at release is NOT an edge.
//  Edge detect:
//   - done_q <= done_i every cycle, in every state.
//   - rise = done_i & ~done_q.
//  FSM:
//   - IDLE: on rise -> latch data_i into shift reg, clear digit accumulator,
//     cnt=WIDTH, go SHIFT.
//   - SHIFT: each cycle, add 3 to every digit >= 5, then shift
//     {digits,shreg} left by 1; cnt--. When cnt reaches 0, load bcd_o,
//     set valid_o, go HOLD.
//   - HOLD: valid_o=1, bcd_o stable. On ready_i -> valid_o=0 next cycle,
//     go IDLE.
//  Timing:
//   - Capture at edge E0; valid_o is high after edge E0+WIDTH (8 cycles).
//   - Back-to-back throughput: one result per WIDTH+2 cycles minimum.
//  Drop rule:
//   - A rise in SHIFT or HOLD is ignored and pulses drop_o for one cycle;
//     the in-flight result is unaffected.
//   - Simultaneous HOLD handshake and rise: the handshake completes and the
//     rise is dropped.
//  bcd_o holds the last converted value after the handshake until the next
//  conversion completes. It is meaningful only while valid_o=1.
//  Input range: data_i is treated as unsigned 0..2**WIDTH-1. The upstream
//  wrap for n>=6 is not this block's concern.
//  Reset mid-operation: the conversion is aborted and no stale valid_o
//  appears after release.
// TESTING
//  1. data_i=120, done_i 0->1 -> valid_o high 8 cycles after capture;
//     bcd_o=12'h120; ready_i=1 -> valid_o low next cycle.
//  2. data_i=255 -> bcd_o=12'h255; data_i=0 -> bcd_o=12'h000;
//     data_i=24 -> bcd_o=12'h024.
//  3. done_i held high 30 cycles -> exactly one conversion, drop_o never pulses.
//  4. Second done rise 3 cycles into SHIFT -> one drop_o pulse;
//     first result (e.g. 12'h006) is delivered intact.
//  5. ready_i low 10 cycles in HOLD -> valid_o/bcd_o stable; a done rise
//     meanwhile -> drop_o; ready_i=1 -> IDLE.
//  6. rst_n low mid-SHIFT -> outputs 0 immediately; done_i high at release
//     -> no conversion until done_i goes low then high.

Source files
------------

// File: rtl/factorial_bcd_out.sv
// ---------------------------------------------------------------------------
// factorial_bcd_out
//
// Result stage behind the factorial unit. A rising edge of done_i captures
// the binary result on data_i. A sequential double-dabble engine then turns
// it into packed BCD, one bit per clock. The digits are offered to the
// display / host-readout logic on a valid/ready handshake.
//
// Ports
//   clk      in   1          single clock, rising edge
//   rst_n    in   1          asynchronous assert, active-low reset
//   done_i   in   1          factorial done level; a rising edge = new result
//   data_i   in   WIDTH      factorial result, sampled on the done_i rise
//   bcd_o    out  4*DIGITS   packed BCD, digit 0 in bits [3:0]
//   valid_o  out  1          bcd_o holds a new, unconsumed result
//   ready_i  in   1          consumer accepts when valid_o && ready_i
//   busy_o   out  1          conversion in progress or result waiting
//   drop_o   out  1          1-cycle pulse: a done edge arrived while busy
//
// Timing: capture at edge E0, WIDTH shift edges follow, and valid_o is high
// after edge E0+WIDTH. The minimum spacing between results is WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module factorial_bcd_out #(
    parameter int WIDTH  = 8,   // binary input width = number of shift cycles
    parameter int DIGITS = 3    // 10**DIGITS must exceed 2**WIDTH-1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  done_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  drop_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               done_q_reg;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic [BCD_W-1:0]   digits_reg, digits_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic               drop_reg, drop_next;

    logic               rise;
    logic               last_shift;
    logic [BCD_W-1:0]   digits_shifted;
    logic [WIDTH-1:0]   shreg_shifted;
    // carry[gi] is the bit shifted into the LSB of digit gi.
    logic [DIGITS-1:0]  carry;

    // -----------------------------------------------------------------------
    // Edge detect. done_q resets high, so a done_i level that is already
    // high when reset is released does not count as a new result.
    // -----------------------------------------------------------------------
    assign rise = done_i & ~done_q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q_reg <= 1'b1;
        end else begin
            done_q_reg <= done_i;
        end
    end

    // -----------------------------------------------------------------------
    // One double-dabble step: add 3 to every digit >= 5, then shift
    // {digits, shreg} left by one bit.
    // For a legal BCD digit d (0..9), bit 3 of (d >= 5 ? d+3 : d) is set
    // exactly when d >= 5. So the bit that leaves a digit is the ge5 flag.
    // Only the low three bits of the adjusted digit survive the shift.
    // -----------------------------------------------------------------------
    assign carry[0]      = shreg_reg[WIDTH-1];
    assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            logic       ge5;
            logic [2:0] adj_low;

            assign digit   = digits_reg[4*gi +: 4];
            assign ge5     = (digit >= 4'd5);
            assign adj_low = ge5 ? (digit[2:0] + 3'd3) : digit[2:0];

            assign digits_shifted[4*gi +: 4] = {adj_low, carry[gi]};

            // The top digit has no neighbour. With 10**DIGITS > 2**WIDTH-1,
            // its ge5 flag never carries real weight.
            if (gi < DIGITS - 1) begin : g_carry
                assign carry[gi+1] = ge5;
            end
        end
    endgenerate

    assign last_shift = (cnt_reg == CNT_W'(1));

    // -----------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            shreg_reg  <= '0;
            digits_reg <= '0;
            cnt_reg    <= '0;
            bcd_reg    <= '0;
            drop_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shreg_reg  <= shreg_next;
            digits_reg <= digits_next;
            cnt_reg    <= cnt_next;
            bcd_reg    <= bcd_next;
            drop_reg   <= drop_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        digits_next = digits_reg;
        cnt_next    = cnt_reg;
        bcd_next    = bcd_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    shreg_next  = data_i;
                    digits_next = '0;
                    cnt_next    = CNT_W'(WIDTH);
                    state_next  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                shreg_next  = shreg_shifted;
                digits_next = digits_shifted;
                cnt_next    = cnt_reg - CNT_W'(1);
                // Publish the post-shift digits in the same cycle as the
                // final shift, so valid_o rises WIDTH edges after capture.
                if (last_shift) begin
                    bcd_next   = digits_shifted;
                    state_next = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (ready_i) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A rise is only accepted in IDLE. Anywhere else it is reported and
    // discarded. This includes the HOLD cycle that completes a handshake,
    // because the state is still HOLD when that rise is seen.
    assign drop_next = rise & (state_reg != ST_IDLE);

    // -----------------------------------------------------------------------
    // FSM process 3: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        valid_o = (state_reg == ST_HOLD);
        busy_o  = (state_reg != ST_IDLE);
        bcd_o   = bcd_reg;
        drop_o  = drop_reg;
    end

endmodule

// File: tb/tb_factorial_bcd_out.sv
// ---------------------------------------------------------------------------
// tb_factorial_bcd_out
//
// Directed bench for factorial_bcd_out (WIDTH=8, DIGITS=3). Expected BCD
// values are hand-computed decimal renderings of the binary inputs.
// ---------------------------------------------------------------------------
module tb_factorial_bcd_out;

    logic        clk;
    logic        rst_n;
    logic        done_i;
    logic [7:0]  data_i;
    logic [11:0] bcd_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        drop_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    factorial_bcd_out #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .done_i  (done_i),
        .data_i  (data_i),
        .bcd_o   (bcd_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .drop_o  (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock. Sampling and driving both happen 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rise on done_i with data d. After this call, edge E0 has been taken.
    task automatic start(input logic [7:0] d);
        data_i = d;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    // Wait for valid_o, counting edges. Gives up after 20 edges.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) break;
            tick();
            cycles++;
        end
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    int lat;
    int vcnt;
    int dcnt;
    int bcnt;

    initial begin
        rst_n   = 1'b0;
        done_i  = 1'b0;
        data_i  = 8'd0;
        ready_i = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy",  32'(busy_o),  32'd0);
        check("rst_drop",  32'(drop_o),  32'd0);
        check("rst_bcd",   32'(bcd_o),   32'h000);
        rst_n = 1'b1;
        tick();

        // ---------------- 1: 120 -> 0x120, latency 8 ----------------
        start(8'd120);
        check("t1_busy_shift",  32'(busy_o),  32'd1);
        check("t1_valid_shift", 32'(valid_o), 32'd0);
        wait_valid(lat);
        check("t1_valid", 32'(valid_o), 32'd1);
        check("t1_lat",   32'(lat),     32'd8);
        check("t1_bcd",   32'(bcd_o),   32'h120);
        $display("conv data=120 bcd=%03h latency=%0d", bcd_o, lat);
        handshake();
        check("t1_valid_after_hs", 32'(valid_o), 32'd0);
        check("t1_busy_after_hs",  32'(busy_o),  32'd0);
        check("t1_bcd_retained",   32'(bcd_o),   32'h120);

        // ---------------- 2: 255, 0, 24 ----------------
        start(8'd255);
        wait_valid(lat);
        check("t2_255_lat", 32'(lat),   32'd8);
        check("t2_255_bcd", 32'(bcd_o), 32'h255);
        $display("conv data=255 bcd=%03h latency=%0d", bcd_o, lat);
        handshake();

        start(8'd0);
        wait_valid(lat);
        check("t2_0_valid", 32'(valid_o), 32'd1);
        check("t2_0_bcd",   32'(bcd_o),   32'h000);
        $display("conv data=0 bcd=%03h latency=%0d", bcd_o, lat);
        handshake();

        start(8'd24);
        wait_valid(lat);
        check("t2_24_valid", 32'(valid_o), 32'd1);
        check("t2_24_bcd",   32'(bcd_o),   32'h024);
        $display("conv data=24 bcd=%03h latency=%0d", bcd_o, lat);
        handshake();

        // ---------------- 3: done held high 30 cycles ----------------
        data_i  = 8'd6;
        done_i  = 1'b1;
        ready_i = 1'b1;
        vcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid_o) vcnt++;
            if (drop_o)  dcnt++;
        end
        check("t3_valid_cycles", 32'(vcnt),  32'd1);
        check("t3_drops",        32'(dcnt),  32'd0);
        check("t3_bcd",          32'(bcd_o), 32'h006);
        check("t3_idle",         32'(busy_o), 32'd0);
        $display("held done: valid_cycles=%0d drops=%0d bcd=%03h", vcnt, dcnt, bcd_o);
        done_i  = 1'b0;
        ready_i = 1'b0;
        tick();

        // ---------------- 4: rise 3 cycles into SHIFT ----------------
        start(8'd6);
        tick();
        tick();
        tick();
        data_i = 8'd99;
        done_i = 1'b1;
        tick();
        check("t4_drop_pulse", 32'(drop_o), 32'd1);
        done_i = 1'b0;
        tick();
        check("t4_drop_end", 32'(drop_o), 32'd0);
        wait_valid(lat);
        check("t4_valid", 32'(valid_o), 32'd1);
        check("t4_bcd",   32'(bcd_o),   32'h006);
        $display("conv data=6 with mid-shift rise: bcd=%03h", bcd_o);
        handshake();
        check("t4_idle", 32'(busy_o), 32'd0);

        // ---------------- 5: stall in HOLD, rise meanwhile ----------------
        start(8'd57);
        wait_valid(lat);
        check("t5_valid", 32'(valid_o), 32'd1);
        vcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                data_i = 8'd200;
                done_i = 1'b1;
            end else begin
                done_i = 1'b0;
            end
            tick();
            if (valid_o && bcd_o == 12'h057) vcnt++;
            if (drop_o) dcnt++;
        end
        check("t5_stable_cycles", 32'(vcnt), 32'd10);
        check("t5_drops",         32'(dcnt), 32'd1);
        $display("hold stall: stable_cycles=%0d drops=%0d bcd=%03h", vcnt, dcnt, bcd_o);
        handshake();
        check("t5_valid_after_hs", 32'(valid_o), 32'd0);
        check("t5_busy_after_hs",  32'(busy_o),  32'd0);

        // -------- simultaneous HOLD handshake and rise: rise dropped --------
        start(8'd1);
        wait_valid(lat);
        check("t5b_bcd", 32'(bcd_o), 32'h001);
        data_i  = 8'd77;
        done_i  = 1'b1;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("t5b_valid", 32'(valid_o), 32'd0);
        check("t5b_drop",  32'(drop_o),  32'd1);
        check("t5b_busy",  32'(busy_o),  32'd0);
        tick();
        check("t5b_no_restart", 32'(busy_o), 32'd0);
        $display("handshake+rise: drop seen, no restart");
        done_i = 1'b0;
        tick();

        // ---------------- 6: reset mid-SHIFT ----------------
        start(8'd200);
        tick();
        tick();
        tick();
        done_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid_o), 32'd0);
        check("t6_rst_busy",  32'(busy_o),  32'd0);
        check("t6_rst_bcd",   32'(bcd_o),   32'h000);
        tick();
        rst_n = 1'b1;
        bcnt = 0;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy_o)  bcnt++;
            if (valid_o) vcnt++;
        end
        check("t6_no_busy_after_rel",  32'(bcnt), 32'd0);
        check("t6_no_valid_after_rel", 32'(vcnt), 32'd0);
        done_i = 1'b0;
        tick();
        start(8'd200);
        wait_valid(lat);
        check("t6_lat", 32'(lat),   32'd8);
        check("t6_bcd", 32'(bcd_o), 32'h200);
        $display("conv after reset data=200 bcd=%03h latency=%0d", bcd_o, lat);
        handshake();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
